// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with mid-bit sampling and a one-entry held byte
//            behind a valid/ack handshake. Optional even-parity checking is
//            enabled with the UART_RX_PARITY_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_START  = 3'd1;
    localparam logic [2:0] C_DATA   = 3'd2;
    localparam logic [2:0] C_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] C_PARITY = 3'd4;
`endif

    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   rx_s_dly_q, rx_s_dly_d;
    logic [2:0]             state_q,    state_d;
    logic [CW-1:0]          cnt_q,      cnt_d;
    logic [2:0]             bit_idx_q,  bit_idx_d;
    logic [7:0]             shift_q,    shift_d;
    logic [7:0]             data_q,     data_d;
    logic                   valid_q,    valid_d;
    logic                   ferr_q,     ferr_d;
    logic                   ovr_q,      ovr_d;
`ifdef UART_RX_PARITY_EN
    logic                   pbad_q,     pbad_d;
    logic                   perr_q,     perr_d;
`endif

    logic w_rx_s;
    logic w_sample;
    logic w_bit_end;
    logic w_load;

    assign w_rx_s    = sync_q[SYNC_STAGES-1];
    assign w_sample  = (cnt_q == C_HALF);
    assign w_bit_end = (cnt_q == C_LAST);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx_in};
        rx_s_dly_d = w_rx_s;
        state_d    = state_q;
        cnt_d      = w_bit_end ? '0 : cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q & ~rx_ack;
        ferr_d     = 1'b0;
        ovr_d      = ovr_q;
        w_load     = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d     = pbad_q;
        perr_d     = 1'b0;
`endif

        case (state_q)
            C_IDLE: begin
                cnt_d = '0;
                // Only a fresh falling edge starts a frame; a held-low line never does.
                if (rx_s_dly_q && !w_rx_s) begin
                    state_d = C_START;
                    cnt_d   = C_ONE;
                end
            end
            C_START: begin
                if (w_sample && w_rx_s) begin
                    state_d = C_IDLE;
                    cnt_d   = '0;
                end else if (w_bit_end) begin
                    state_d   = C_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            C_DATA: begin
                if (w_sample) begin
                    shift_d = {w_rx_s, shift_q[7:1]};
                end
                if (w_bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = C_PARITY;
`else
                        state_d = C_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            C_PARITY: begin
                if (w_sample) begin
                    pbad_d = ^{shift_q, w_rx_s};
                end
                if (w_bit_end) begin
                    state_d = C_STOP;
                end
            end
`endif
            C_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (w_sample) begin
                    state_d = C_IDLE;
                    cnt_d   = '0;
                    if (w_rx_s) begin
                        w_load = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d = pbad_q;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = C_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load overrides a same-cycle ack; overrun only when the old byte was not taken.
        if (w_load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '1;
            rx_s_dly_q <= 1'b1;
            state_q    <= C_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q     <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            rx_s_dly_q <= rx_s_dly_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            pbad_q     <= pbad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif

endmodule

`default_nettype wire
